button_event_queue: RTL

//  Sits directly downstream of the per-button debouncers: takes their one-cycle press pulses,

---
 rtl/vm_pkg.sv | 20 ++
 rtl/btn_evt_fifo.sv | 70 +++++++
 rtl/button_event_queue.sv | 116 +++++++++++
 3 files changed

// File: rtl/vm_pkg.sv
// Shared vending-machine definitions used by the button event path.
// Contents:
//   BTN_*        button index constants (bit position in pb_pulse, value of evt_code)
//   *_DEF        default button count and event FIFO depth
//   evt_code_w   width of an event code for a given button count (minimum 1 bit)
package vm_pkg;

  localparam int unsigned BTN_COIN5   = 0;
  localparam int unsigned BTN_COIN10  = 1;
  localparam int unsigned BTN_COIN25  = 2;
  localparam int unsigned BTN_SELECT  = 3;

  localparam int unsigned NUM_BTN_DEF = 4;
  localparam int unsigned DEPTH_DEF   = 8;

  function automatic int unsigned evt_code_w(input int unsigned num_btn);
    return (num_btn > 1) ? $clog2(num_btn) : 1;
  endfunction

endpackage

// File: rtl/btn_evt_fifo.sv
// Synchronous FIFO holding serialised button events.
// Full/empty are derived from an occupancy count. A push while full and a pop while empty are
// ignored. The head output reads as zero while empty.
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset (empties the FIFO)
//   push       write push_data (ignored when full)
//   push_data  entry to write
//   pop        remove head entry (ignored when empty)
//   pop_data   head entry
//   count      entries currently stored
//   full       count == DEPTH
//   empty      count == 0
module btn_evt_fifo #(
  parameter int unsigned  WIDTH = 2,
  parameter int unsigned  DEPTH = 8,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned NW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [NW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [NW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    full    = (count_q == NW'(DEPTH));
    empty   = (count_q == '0);
    // Fullness is judged before any same-cycle pop, so a pop never frees space for this push.
    do_push = push && !full;
    do_pop  = pop && !empty;
    count_d = count_q;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + NW'(1);
      2'b01:   count_d = count_q - NW'(1);
      default: count_d = count_q;
    endcase
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !rst) mem_q[wr_ptr_q] <= push_data;
  end

  assign pop_data = empty ? '0 : mem_q[rd_ptr_q];
  assign count    = count_q;

endmodule

// File: rtl/button_event_queue.sv
// Button event queue: collects one-cycle press pulses from the debouncers, serialises
// simultaneous presses (lowest index first, one per cycle) and buffers them for the vending
// FSM, which pops through a valid/ready handshake.
// Optional feature macro: BTN_EVT_TIMESTAMP_EN adds a free-running timestamp counter whose value
// at the push edge is stored with each event and presented on evt_ts.
// Ports:
//   clk        system clock (50 MHz)
//   rst        synchronous active-high reset; discards pending and queued events
//   pb_pulse   one-cycle press pulses, bit i = button i
//   evt_valid  head event available
//   evt_ready  consumer accepts head event when evt_valid & evt_ready
//   evt_code   button index of head event
//   evt_count  entries currently queued
//   ovf        sticky: a press was coalesced into one already pending
//   ovf_clr    clears ovf (a same-cycle coalesce wins)
//   evt_ts     head-event timestamp (BTN_EVT_TIMESTAMP_EN only)
module button_event_queue
  import vm_pkg::*;
#(
  parameter int unsigned  NUM_BTN = NUM_BTN_DEF,
  parameter int unsigned  DEPTH   = DEPTH_DEF,
  parameter int unsigned  TS_W    = 16,
  localparam int unsigned CW      = evt_code_w(NUM_BTN),
  localparam int unsigned NW      = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] pb_pulse,
  output logic               evt_valid,
  input  logic               evt_ready,
  output logic [CW-1:0]      evt_code,
  output logic [NW-1:0]      evt_count,
  output logic               ovf,
  input  logic               ovf_clr
`ifdef BTN_EVT_TIMESTAMP_EN
  ,
  output logic [TS_W-1:0]    evt_ts
`endif
);

`ifdef BTN_EVT_TIMESTAMP_EN
  localparam bit TsEn = 1'b1;
`else
  localparam bit TsEn = 1'b0;
`endif
  localparam int unsigned FW = CW + (TsEn ? TS_W : 0);

  logic [NUM_BTN-1:0] pending_q, pending_d, push_sel;
  logic [CW-1:0]      push_idx;
  logic               push, pop, coalesce;
  logic               fifo_full, fifo_empty;
  logic               ovf_q, ovf_d;
  logic [FW-1:0]      push_data, head_data;

  always_comb begin
    push     = (pending_q != '0) && !fifo_full;
    // Isolate the lowest set pending bit.
    push_sel = push ? (pending_q & (~pending_q + NUM_BTN'(1))) : '0;
    push_idx = '0;
    for (int i = NUM_BTN - 1; i >= 0; i--) begin
      if (pending_q[i]) push_idx = CW'(i);
    end
    // A pulse on the bit leaving this cycle is a new event; on a bit left waiting it is lost.
    coalesce  = |(pb_pulse & pending_q & ~push_sel);
    pending_d = (pending_q & ~push_sel) | pb_pulse;
    ovf_d     = ovf_q;
    if (ovf_clr)  ovf_d = 1'b0;
    if (coalesce) ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      pending_q <= pending_d;
      ovf_q     <= ovf_d;
    end
  end

`ifdef BTN_EVT_TIMESTAMP_EN
  logic [TS_W-1:0] ts_q;

  always_ff @(posedge clk) begin
    if (rst) ts_q <= '0;
    else     ts_q <= ts_q + TS_W'(1);
  end

  assign push_data = {ts_q, push_idx};
  assign evt_code  = head_data[CW-1:0];
  assign evt_ts    = head_data[FW-1:CW];
`else
  assign push_data = push_idx;
  assign evt_code  = head_data;
`endif

  assign pop       = evt_valid && evt_ready;
  assign evt_valid = !fifo_empty;
  assign ovf       = ovf_q;

  btn_evt_fifo #(
    .WIDTH (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .pop_data  (head_data),
    .count     (evt_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule
